// File: rtl/ifetch_unit.sv
// Instruction fetch front end: issues word reads on the instruction bus,
// tags returned words with their fetch address and buffers them for decode.
// A redirect or IRQ flushes the buffer and marks in-flight reads as stale.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] IRQ_VECTOR = 32'h0000_0004,
   parameter int          DEPTH      = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        o_ibus_req,
   output logic [31:0] o_ibus_addr,
   input  logic        i_ibus_ready,
   input  logic        i_ibus_rvalid,
   input  logic [31:0] i_ibus_rdata,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_irq,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   input  logic        i_inst_ready
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [CW-1:0] cnt_t;
   typedef logic [PW-1:0] ptr_t;

   localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];
   localparam cnt_t        FULL_C  = DEPTH[CW-1:0];

   // Circular pointer advance for a DEPTH-entry ring.
   function automatic ptr_t ptr_inc(input ptr_t p);
      ptr_inc = (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   logic        run_q;
   logic [31:0] fetch_pc;
   cnt_t        outstanding;
   cnt_t        outstanding_nxt;
   cnt_t        stale;
   cnt_t        fifo_count;
   ptr_t        inf_rd, inf_wr;
   ptr_t        fifo_rd, fifo_wr;
   logic [31:0] inf_pc    [DEPTH];
   logic [31:0] fifo_word [DEPTH];
   logic [31:0] fifo_pc   [DEPTH];
   logic        flush, issue, keep, pop;
   logic [CW:0] credit_used;
   logic [31:0] redirect_target;

   // Credits cover both in-flight reads (stale ones included) and buffered
   // words, so every returning response is guaranteed a FIFO slot.
   assign credit_used     = {1'b0, outstanding} + {1'b0, fifo_count};
   assign o_ibus_req      = run_q & (credit_used < DEPTH_C);
   assign o_ibus_addr     = fetch_pc & 32'hFFFF_FFFC;
   assign issue           = o_ibus_req & i_ibus_ready;
   assign flush           = i_redirect | i_irq;
   assign keep            = i_ibus_rvalid & ~flush & (stale == '0);
   assign pop             = o_inst_valid & i_inst_ready & ~flush;
   assign outstanding_nxt = outstanding + cnt_t'(issue) - cnt_t'(i_ibus_rvalid);
   assign redirect_target = i_irq ? (IRQ_VECTOR & 32'hFFFF_FFFC)
                                  : (i_redirect_pc & 32'hFFFF_FFFC);

   // Head of the buffer; data is forced to zero when nothing is buffered.
   assign o_inst_valid = (fifo_count != '0);
   assign o_inst       = o_inst_valid ? fifo_word[fifo_rd] : '0;
   assign o_inst_pc    = o_inst_valid ? fifo_pc[fifo_rd]   : '0;

   // Control state: fetch address, credit counters and ring pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q       <= 1'b0;
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         stale       <= '0;
         fifo_count  <= '0;
         inf_rd      <= '0;
         inf_wr      <= '0;
         fifo_rd     <= '0;
         fifo_wr     <= '0;
      end else begin
         run_q       <= 1'b1;
         outstanding <= outstanding_nxt;

         if (flush)
            fetch_pc <= redirect_target;
         else if (issue)
            fetch_pc <= fetch_pc + 32'd4;

         // Everything still in flight after a flush cycle belongs to the old stream.
         if (flush)
            stale <= outstanding_nxt;
         else if (i_ibus_rvalid && (stale != '0))
            stale <= stale - cnt_t'(1);

         if (issue)
            inf_wr <= ptr_inc(inf_wr);
         if (i_ibus_rvalid)
            inf_rd <= ptr_inc(inf_rd);

         if (flush) begin
            fifo_count <= '0;
            fifo_rd    <= fifo_wr;
         end else begin
            fifo_count <= fifo_count + cnt_t'(keep) - cnt_t'(pop);
            if (keep)
               fifo_wr <= ptr_inc(fifo_wr);
            if (pop)
               fifo_rd <= ptr_inc(fifo_rd);
         end
      end
   end

   // Storage: in-flight address tags and buffered {word, pc} entries.
   always_ff @(posedge clk) begin
      if (issue)
         inf_pc[inf_wr] <= o_ibus_addr;
      if (keep) begin
         fifo_word[fifo_wr] <= i_ibus_rdata;
         fifo_pc[fifo_wr]   <= inf_pc[inf_rd];
      end
   end

   // Bus protocol and buffer occupancy sanity checks.
   rvalid_has_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      !(i_ibus_rvalid && (outstanding == '0)));
   fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(keep && !pop && (fifo_count == FULL_C)));

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit (DEPTH=2): bus responder answers one cycle
// after each accepted request with rdata = addr ^ 32'hA5A5A5A5.
module tb_ifetch_unit;

   localparam logic [31:0] XK = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        o_ibus_req;
   logic [31:0] o_ibus_addr;
   logic        i_ibus_ready;
   logic        i_ibus_rvalid;
   logic [31:0] i_ibus_rdata;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        i_irq;
   logic        o_inst_valid;
   logic [31:0] o_inst;
   logic [31:0] o_inst_pc;
   logic        i_inst_ready;

   int errors = 0;
   int checks = 0;
   logic        resp_en;
   logic [31:0] pending [$];
   logic [31:0] acc_log [$];
   logic [31:0] con_pc  [$];
   logic [31:0] con_word[$];

   ifetch_unit #(.RESET_PC(32'h0), .IRQ_VECTOR(32'h4), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .o_ibus_req(o_ibus_req), .o_ibus_addr(o_ibus_addr), .i_ibus_ready(i_ibus_ready),
      .i_ibus_rvalid(i_ibus_rvalid), .i_ibus_rdata(i_ibus_rdata),
      .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .i_irq(i_irq),
      .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
      .i_inst_ready(i_inst_ready)
   );

   always #5 clk = ~clk;

   // Record accepted requests and consumed instructions at the active edge.
   always @(posedge clk) begin
      if (rst_n && o_ibus_req && i_ibus_ready) begin
         acc_log.push_back(o_ibus_addr);
         pending.push_back(o_ibus_addr);
      end
      if (rst_n && o_inst_valid && i_inst_ready) begin
         con_pc.push_back(o_inst_pc);
         con_word.push_back(o_inst);
      end
   end

   // In-order bus responder, one cycle of latency; reset clears it.
   always @(negedge clk) begin
      if (!rst_n) begin
         pending.delete();
         i_ibus_rvalid = 1'b0;
         i_ibus_rdata  = '0;
      end else if (resp_en && pending.size() > 0) begin
         i_ibus_rdata  = pending.pop_front() ^ XK;
         i_ibus_rvalid = 1'b1;
      end else begin
         i_ibus_rvalid = 1'b0;
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; i_ibus_ready = 1'b0; i_redirect = 1'b0; i_irq = 1'b0;
      i_redirect_pc = '0; i_inst_ready = 1'b0; resp_en = 1'b1;
      repeat (3) @(negedge clk);
      acc_log.delete(); con_pc.delete(); con_word.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      @(negedge clk); #1;
      checks++; if (o_ibus_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", o_ibus_req); end
      checks++; if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_inst_valid); end
      checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h want 0", o_inst); end
      checks++; if (o_inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", o_inst_pc); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (o_ibus_req !== 1'b1 || o_ibus_addr !== 32'h0) begin
         errors++; $display("FAIL reset_first_req got req=%b addr=%h want req=1 addr=0", o_ibus_req, o_ibus_addr); end
   endtask

   task automatic test_stream();
      do_reset();
      i_ibus_ready = 1'b1; i_inst_ready = 1'b1;
      for (int i = 0; i < 40 && con_pc.size() < 5; i++) @(negedge clk);
      checks++; if (con_pc.size() < 5) begin errors++; $display("FAIL stream_count got %0d want 5", con_pc.size()); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (acc_log[k] !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr%0d got %h want %h", k, acc_log[k], 32'(4 * k)); end
         checks++; if (con_pc[k] !== 32'(4 * k) || con_word[k] !== (32'(4 * k) ^ XK)) begin
            errors++; $display("FAIL stream_inst%0d got pc=%h w=%h want pc=%h w=%h", k, con_pc[k], con_word[k], 32'(4 * k), 32'(4 * k) ^ XK); end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      i_ibus_ready = 1'b1; i_inst_ready = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (acc_log.size() != 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", acc_log.size()); end
      checks++; if (acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4) begin
         errors++; $display("FAIL bp_addrs got %h,%h want 0,4", acc_log[0], acc_log[1]); end
      checks++; if (o_ibus_req !== 1'b0) begin errors++; $display("FAIL bp_req_low got %b want 0", o_ibus_req); end
      checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0 || o_inst !== XK) begin
         errors++; $display("FAIL bp_head got v=%b pc=%h w=%h want v=1 pc=0 w=%h", o_inst_valid, o_inst_pc, o_inst, XK); end
      i_inst_ready = 1'b1;
      for (int i = 0; i < 20 && acc_log.size() < 3; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      checks++; if (con_pc.size() < 2 || con_pc[0] !== 32'h0 || con_pc[1] !== 32'h4) begin
         errors++; $display("FAIL bp_pop_order got n=%0d %h,%h want 0,4", con_pc.size(), con_pc[0], con_pc[1]); end
      checks++; if (con_word[1] !== (32'h4 ^ XK)) begin errors++; $display("FAIL bp_word1 got %h want %h", con_word[1], 32'h4 ^ XK); end
      checks++; if (acc_log.size() < 3 || acc_log[2] !== 32'h8) begin
         errors++; $display("FAIL bp_resume got n=%0d %h want 8", acc_log.size(), acc_log[2]); end
   endtask

   task automatic test_redirect_flush();
      int mark;
      do_reset();
      resp_en = 1'b0; i_ibus_ready = 1'b1; i_inst_ready = 1'b1;
      for (int i = 0; i < 20 && acc_log.size() < 2; i++) @(negedge clk);
      checks++; if (acc_log.size() != 2) begin errors++; $display("FAIL rd_setup got %0d want 2", acc_log.size()); end
      i_redirect = 1'b1; i_redirect_pc = 32'h103; resp_en = 1'b1;
      @(negedge clk);
      i_redirect = 1'b0; i_redirect_pc = '0;
      mark = acc_log.size();
      checks++; if (o_ibus_addr !== 32'h100 || o_inst_valid !== 1'b0) begin
         errors++; $display("FAIL rd_after_flush got addr=%h v=%b want 100 0", o_ibus_addr, o_inst_valid); end
      for (int i = 0; i < 30 && con_pc.size() < 2; i++) @(negedge clk);
      checks++; if (acc_log.size() <= mark || acc_log[mark] !== 32'h100) begin
         errors++; $display("FAIL rd_next_addr got %h want 100", acc_log[mark]); end
      checks++; if (con_pc.size() < 2 || con_pc[0] !== 32'h100 || con_word[0] !== (32'h100 ^ XK)) begin
         errors++; $display("FAIL rd_first_inst got pc=%h w=%h want 100 %h", con_pc[0], con_word[0], 32'h100 ^ XK); end
      checks++; if (con_pc[1] !== 32'h104) begin errors++; $display("FAIL rd_second_inst got %h want 104", con_pc[1]); end
   endtask

   task automatic test_irq_priority();
      int mark;
      do_reset();
      i_ibus_ready = 1'b1; i_inst_ready = 1'b1;
      repeat (8) @(negedge clk);
      i_irq = 1'b1; i_redirect = 1'b1; i_redirect_pc = 32'h200;
      @(negedge clk);
      i_irq = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
      mark = acc_log.size();
      con_pc.delete(); con_word.delete();
      checks++; if (o_ibus_addr !== 32'h4) begin errors++; $display("FAIL irq_addr got %h want 4", o_ibus_addr); end
      checks++; if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL irq_fifo_empty got %b want 0", o_inst_valid); end
      for (int i = 0; i < 30 && con_pc.size() < 1; i++) @(negedge clk);
      checks++; if (acc_log.size() <= mark || acc_log[mark] !== 32'h4) begin
         errors++; $display("FAIL irq_next_accept got %h want 4", acc_log[mark]); end
      checks++; if (con_pc.size() < 1 || con_pc[0] !== 32'h4 || con_word[0] !== (32'h4 ^ XK)) begin
         errors++; $display("FAIL irq_first_inst got pc=%h w=%h want 4 %h", con_pc[0], con_word[0], 32'h4 ^ XK); end
   endtask

   task automatic test_wrap();
      int mark;
      do_reset();
      i_ibus_ready = 1'b1; i_inst_ready = 1'b1;
      repeat (6) @(negedge clk);
      i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      i_redirect = 1'b0; i_redirect_pc = '0;
      mark = acc_log.size();
      con_pc.delete(); con_word.delete();
      for (int i = 0; i < 30 && con_pc.size() < 3; i++) @(negedge clk);
      checks++; if (acc_log.size() < mark + 2 || acc_log[mark] !== 32'hFFFF_FFFC || acc_log[mark + 1] !== 32'h0) begin
         errors++; $display("FAIL wrap_addrs got %h,%h want fffffffc,0", acc_log[mark], acc_log[mark + 1]); end
      checks++; if (con_pc.size() < 3 || con_pc[0] !== 32'hFFFF_FFFC || con_word[0] !== (32'hFFFF_FFFC ^ XK)) begin
         errors++; $display("FAIL wrap_inst0 got pc=%h w=%h want fffffffc %h", con_pc[0], con_word[0], 32'hFFFF_FFFC ^ XK); end
      checks++; if (con_pc[1] !== 32'h0 || con_word[1] !== XK) begin
         errors++; $display("FAIL wrap_inst1 got pc=%h w=%h want 0 %h", con_pc[1], con_word[1], XK); end
      checks++; if (con_pc[2] !== 32'h4) begin errors++; $display("FAIL wrap_inst2 got %h want 4", con_pc[2]); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      i_ibus_ready = 1'b1; i_inst_ready = 1'b0;
      for (int i = 0; i < 20 && acc_log.size() < 2; i++) @(negedge clk);
      // One word (pc 0) buffered, pc 4 in flight with its response being driven now.
      checks++; if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0) begin
         errors++; $display("FAIL mid_setup got v=%b pc=%h want 1 0", o_inst_valid, o_inst_pc); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (o_inst_valid !== 1'b0 || o_inst !== 32'h0 || o_inst_pc !== 32'h0) begin
         errors++; $display("FAIL mid_outputs got v=%b w=%h pc=%h want 0 0 0", o_inst_valid, o_inst, o_inst_pc); end
      checks++; if (o_ibus_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b want 0", o_ibus_req); end
      repeat (3) @(negedge clk);
      acc_log.delete(); con_pc.delete(); con_word.delete();
      rst_n = 1'b1; i_inst_ready = 1'b1;
      for (int i = 0; i < 30 && con_pc.size() < 2; i++) @(negedge clk);
      checks++; if (acc_log.size() < 1 || acc_log[0] !== 32'h0) begin
         errors++; $display("FAIL mid_first_addr got %h want 0", acc_log[0]); end
      checks++; if (con_pc.size() < 2 || con_pc[0] !== 32'h0 || con_word[0] !== XK || con_pc[1] !== 32'h4) begin
         errors++; $display("FAIL mid_first_insts got pc=%h w=%h pc1=%h want 0 %h 4", con_pc[0], con_word[0], con_pc[1], XK); end
   endtask

   initial begin
      rst_n = 1'b0; resp_en = 1'b1;
      i_ibus_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_irq = 1'b0; i_inst_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_flush();
      test_irq_priority();
      test_wrap();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
